// File: rtl/trace_release_queue.sv
// Timestamp-release buffer between the trace parser and the DRAM request queue.
// Records are held in FIFO order. Each one is released once the CPU cycle counter reaches its timestamp.
module trace_release_queue #(
  parameter int ADDRESS_WIDTH = 33,
  parameter int TIME_W        = 64,
  parameter int OP_W          = 2,
  parameter int DEPTH         = 8
) (
  input  logic                       CPU_clock,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TIME_W-1:0]          in_time,
  input  logic [OP_W-1:0]            in_op,
  input  logic [ADDRESS_WIDTH-1:0]   in_addr,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TIME_W-1:0]          out_time,
  output logic [OP_W-1:0]            out_op,
  output logic [ADDRESS_WIDTH-1:0]   out_addr,
  input  logic                       ff_en,
  output logic [TIME_W-1:0]          cycle_count,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       err_order,
  output logic                       err_op,
  output logic                       done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OP_W-1:0]  OP_IFETCH = OP_W'(2);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [TIME_W-1:0]        mem_time [DEPTH];
  logic [OP_W-1:0]          mem_op   [DEPTH];
  logic [ADDRESS_WIDTH-1:0] mem_addr [DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [TIME_W-1:0]        last_time;
  logic [OCC_W-1:0]         occ_next;
  logic                     accept, op_ok, order_ok, push, pop;

  assign in_ready = (state == RUN) && (occupancy < OCC_FULL);
  assign accept   = in_valid && in_ready;
  assign op_ok    = (in_op <= OP_IFETCH);
  assign order_ok = (in_time >= last_time);
  assign push     = accept && op_ok && order_ok;

  assign out_time  = mem_time[rd_ptr];
  assign out_op    = mem_op[rd_ptr];
  assign out_addr  = mem_addr[rd_ptr];
  assign out_valid = (occupancy != '0) && (out_time <= cycle_count);
  assign pop       = out_valid && out_ready;
  assign done      = (state == DONE);

  always_comb begin
    occ_next = occupancy;
    case ({push, pop})
      2'b10:   occ_next = occupancy + OCC_W'(1);
      2'b01:   occ_next = occupancy - OCC_W'(1);
      default: occ_next = occupancy;
    endcase
  end

  // DONE is reached in the cycle right after the final pop, so the check uses the post-pop count.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (accept && in_last) state_next = DRAIN;
      DRAIN:   if (occ_next == '0)    state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge CPU_clock) begin
    if (!rst_n) begin
      state       <= RUN;
      occupancy   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      last_time   <= '0;
      cycle_count <= '0;
      err_order   <= 1'b0;
      err_op      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_time[i] <= '0;
        mem_op[i]   <= '0;
        mem_addr[i] <= '0;
      end
    end else begin
      state     <= state_next;
      occupancy <= occ_next;

      if (&cycle_count)
        cycle_count <= cycle_count;
      else if (ff_en && (occupancy != '0) && (out_time > cycle_count))
        cycle_count <= out_time;
      else
        cycle_count <= cycle_count + TIME_W'(1);

      if (push) begin
        mem_time[wr_ptr] <= in_time;
        mem_op[wr_ptr]   <= in_op;
        mem_addr[wr_ptr] <= in_addr;
        wr_ptr           <= wr_ptr + PTR_W'(1);
        last_time        <= in_time;
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);

      if (accept && !op_ok)
        err_op <= 1'b1;
      else if (accept && !order_ok)
        err_order <= 1'b1;
    end
  end

endmodule

// File: doc/trace_release_queue.md
# trace_release_queue

Parametrised timestamp-release buffer that sits between the trace parser and the DRAM request queue. It accepts parsed trace records (CPU time, opcode, address) over a valid/ready handshake and stores up to DEPTH of them in order. It keeps the CPU cycle counter and releases each record to the controller no earlier than its trace timestamp. Optional fast-forward, input validation and end-of-trace tracking are included.

## Interface
- ADDRESS_WIDTH, 33, request address width
- TIME_W, 64, timestamp and cycle counter width
- OP_W, 2, opcode width; codes 0 = read, 1 = write, 2 = ifetch; all other codes are invalid
- DEPTH, 8, record storage entries; power of two, at least 2
- CPU_clock  in  1  sole clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  parser record valid
- in_ready  out  1  block can accept a record this cycle
- in_time  in  TIME_W  record timestamp
- in_op  in  OP_W  record opcode
- in_addr  in  ADDRESS_WIDTH  record address
- in_last  in  1  qualifies the final trace record
- out_valid  out  1  head record is releasable
- out_ready  in  1  controller accepts the head record
- out_time, out_op, out_addr  out  TIME_W/OP_W/ADDRESS_WIDTH  head record fields
- ff_en  in  1  fast-forward enable
- cycle_count  out  TIME_W  current CPU cycle
- occupancy  out  $clog2(DEPTH)+1  stored record count
- err_order  out  1  sticky: a record was dropped for a decreasing timestamp
- err_op  out  1  sticky: a record was dropped for an invalid opcode
- done  out  1  sticky: end of trace seen and all records released

## Operation
- FSM states:
  - RUN: inputs are accepted.
  - DRAIN: entered on an accepted handshake with in_last=1, whether that record is stored or dropped.
  - DONE: entered from DRAIN when occupancy reaches 0 and no handshake is in flight.
  - DONE is left only by reset.
- in_ready = (state==RUN) && (occupancy<DEPTH).
- An accepted record is one with in_valid && in_ready.
- Validation of each accepted record:
  - If in_op is invalid, drop the record and set err_op.
  - Otherwise, if in_time < last_time, drop the record and set err_order.
  - Otherwise, store the record and set last_time = in_time.
  - Equal timestamps are legal.
  - Both checks are evaluated, but one drop sets only the higher-priority flag (err_op).
- Release:
  - out_valid = (occupancy != 0) && (head.time <= cycle_count).
  - out_* always show the head record, even while out_valid=0.
  - A pop happens on out_valid && out_ready.
- cycle_count: next value by priority:
  - Saturate at all-ones.
  - If ff_en && occupancy != 0 && head.time > cycle_count, load head.time.
  - Otherwise increment by 1.
- Push and pop in the same cycle leave occupancy unchanged.
- The storage is a circular buffer with wrapping read/write pointers; ordering is strictly FIFO.
- Reset clears every register listed under Timing; a reset mid-operation flushes all stored records.

## Timing
- Reset values (cycle after rst_n=0 is sampled):
  - cycle_count=0, occupancy=0, last_time=0.
  - out_valid=0, in_ready=1, state=RUN.
  - err_order=0, err_op=0, done=0.
  - out_* fields=0.
- cycle_count increments on every non-reset edge; the first post-reset cycle reads 0.
- Storage has no bypass. A record accepted in cycle N updates occupancy at N+1 and can set out_valid no earlier than N+1.
- out_valid is combinational from the registered head and cycle_count.
- in_ready is combinational from state and registered occupancy; it ignores a same-cycle pop.
- Full condition: in_ready=0 until the cycle after a pop.
- The fast-forward load takes effect at the next edge. out_valid rises in that same following cycle if the head matches.
- err_* and done update one cycle after the causing handshake or drain completion.
- Minimum release latency:
  - timestamp ≤ cycle_count at storage: 1 cycle from the input handshake.
  - otherwise: released when cycle_count == timestamp.

## Test plan
- **Release at timestamp:** after reset, push {t=5, op=0, addr=0x1_0000_0040}; hold out_ready=1 and ff_en=0. Required: out_valid first high when cycle_count=5; popped in that cycle; occupancy back to 0 at the next cycle.
- **Fast-forward:** with ff_en=1, push t=1000 at cycle 2. Required: cycle_count=1000 at cycle 4; out_valid high at cycle 4; t=1000 popped.
- **Full and backpressure:** with out_ready=0, push DEPTH records with t=0, then assert in_valid with a 9th record. Required:
  - in_ready=0 while full; occupancy=8.
  - One pop re-asserts in_ready on the next cycle.
  - Output order is identical to input order across pointer wrap (push 20 records total).
- **Validation:** push t=10/op=1, then t=9/op=0, then t=12/op=3, then t=10/op=2. Required:
  - Only the t=10/op=1 and t=10/op=2 records are released.
  - err_order=1 and err_op=1, each set one cycle after its offending handshake.
  - last_time ends at 10.
- **End of trace:** push three records, the last with in_last=1. Required:
  - in_ready=0 from the next cycle.
  - done=1 one cycle after the final pop; done stays high.
  - A further in_valid is ignored.
- **Reset mid-operation:** with 5 records stored and cycle_count=37, assert rst_n=0 for one edge. Required: all outputs at reset values; a subsequent push of t=0 releases one cycle after the handshake.
